// File: rtl/alu_cmd_engine.sv
// alu_cmd_engine: handshaked 8-bit ALU responder.
// Single-cycle ops answer one cycle after acceptance. A non-zero divide runs an
// 8-step restoring divider and answers nine cycles after acceptance.
// op_count counts completed response handshakes and wraps modulo 2^CNT_W.
module alu_cmd_engine #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [7:0]       cmd_a,
    input  logic [7:0]       cmd_b,
    input  logic [3:0]       cmd_sel,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [7:0]       rsp_out,
    output logic             rsp_carry,
    output logic             rsp_err,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Single-cycle result: returns {err, carry, out[7:0]}.
    // A non-zero divide never takes this path; only divide-by-zero is answered here.
    function automatic logic [9:0] alu_simple(input logic [7:0] a,
                                              input logic [7:0] b,
                                              input logic [3:0] sel);
        logic [8:0]  sum;
        logic [15:0] prod;
        logic [9:0]  res;
        sum  = {1'b0, a} + {1'b0, b};
        prod = {8'd0, a} * {8'd0, b};
        res  = 10'd0;
        case (sel)
            4'h0: res = {1'b0, sum[8], sum[7:0]};
            4'h1: res = {1'b0, (a < b), a - b};
            4'h2: res = {1'b0, (prod[15:8] != 8'd0), prod[7:0]};
            4'h3: res = (b == 8'd0) ? {1'b1, 1'b0, 8'hFF} : 10'd0;
            4'h4: res = {2'b00, a[6:0], 1'b0};
            4'h5: res = {2'b00, 1'b0, a[7:1]};
            4'h6: res = {2'b00, a[6:0], a[7]};
            4'h7: res = {2'b00, a[0], a[7:1]};
            4'h8: res = {2'b00, a & b};
            4'h9: res = {2'b00, a | b};
            4'hA: res = {2'b00, a ^ b};
            4'hB: res = {2'b00, ~(a | b)};
            4'hC: res = {2'b00, ~(a & b)};
            4'hD: res = {2'b00, ~(a ^ b)};
            4'hE: res = {2'b00, 7'd0, (a > b)};
            4'hF: res = {2'b00, 7'd0, (a == b)};
            default: res = 10'd0;
        endcase
        return res;
    endfunction

    state_t           state_r, state_s;
    logic [7:0]       out_r, out_s;
    logic             carry_r, carry_s;
    logic             err_r, err_s;
    logic [CNT_W-1:0] count_r, count_s;
    logic [7:0]       quo_r, quo_s;       // dividend shifts out, quotient shifts in
    logic [7:0]       rem_r, rem_s;       // partial remainder
    logic [7:0]       divisor_r, divisor_s;
    logic [3:0]       iter_r, iter_s;

    logic [9:0]       alu_res_s;
    logic [8:0]       trial_s;
    logic [7:0]       diff_s;
    logic             fits_s;
    logic             div_start_s;

    assign alu_res_s   = alu_simple(cmd_a, cmd_b, cmd_sel);
    assign div_start_s = (cmd_sel == 4'd3) && (cmd_b != 8'd0);

    // One restoring step: shift the next dividend bit into the remainder and
    // subtract the divisor when it fits. The difference is below the divisor,
    // so the low 8 bits hold it exactly.
    assign trial_s = {rem_r, quo_r[7]};
    assign fits_s  = (trial_s >= {1'b0, divisor_r});
    assign diff_s  = trial_s[7:0] - divisor_r;

    assign cmd_ready = (state_r == ST_IDLE);
    assign rsp_valid = (state_r == ST_RESP);
    assign rsp_out   = out_r;
    assign rsp_carry = carry_r;
    assign rsp_err   = err_r;
    assign op_count  = count_r;

    // Next-state and datapath update; every register holds unless told otherwise.
    always_comb begin
        state_s   = state_r;
        out_s     = out_r;
        carry_s   = carry_r;
        err_s     = err_r;
        count_s   = count_r;
        quo_s     = quo_r;
        rem_s     = rem_r;
        divisor_s = divisor_r;
        iter_s    = iter_r;
        case (state_r)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (div_start_s) begin
                        quo_s     = cmd_a;
                        rem_s     = 8'd0;
                        divisor_s = cmd_b;
                        iter_s    = 4'd0;
                        state_s   = ST_DIV;
                    end else begin
                        out_s   = alu_res_s[7:0];
                        carry_s = alu_res_s[8];
                        err_s   = alu_res_s[9];
                        state_s = ST_RESP;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_DIV: begin
                if (fits_s) begin
                    rem_s = diff_s;
                end else begin
                    rem_s = trial_s[7:0];
                end
                quo_s = {quo_r[6:0], fits_s};
                if (iter_r == 4'd7) begin
                    out_s   = {quo_r[6:0], fits_s};
                    carry_s = 1'b0;
                    err_s   = 1'b0;
                    state_s = ST_RESP;
                end else begin
                    iter_s = iter_r + 4'd1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    count_s = count_r + CNT_W'(1);
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RESP;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset; reset drops any divide in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            out_r     <= 8'd0;
            carry_r   <= 1'b0;
            err_r     <= 1'b0;
            count_r   <= '0;
            quo_r     <= 8'd0;
            rem_r     <= 8'd0;
            divisor_r <= 8'd0;
            iter_r    <= 4'd0;
        end else begin
            state_r   <= state_s;
            out_r     <= out_s;
            carry_r   <= carry_s;
            err_r     <= err_s;
            count_r   <= count_s;
            quo_r     <= quo_s;
            rem_r     <= rem_s;
            divisor_r <= divisor_s;
            iter_r    <= iter_s;
        end
    end

endmodule

// File: tb/tb_alu_cmd_engine.sv
// tb_alu_cmd_engine: directed and randomized checks of alu_cmd_engine against
// an arithmetic reference model. Counter width is 4 so wrap-around is reachable.
module tb_alu_cmd_engine;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [7:0]       cmd_a;
    logic [7:0]       cmd_b;
    logic [3:0]       cmd_sel;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [7:0]       rsp_out;
    logic             rsp_carry;
    logic             rsp_err;
    logic [CNT_W-1:0] op_count;

    int checks    = 0;
    int errors    = 0;
    int exp_count = 0;

    alu_cmd_engine #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .cmd_sel   (cmd_sel),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_out   (rsp_out),
        .rsp_carry (rsp_carry),
        .rsp_err   (rsp_err),
        .op_count  (op_count)
    );

    always #5 clk = ~clk;

    // Reference model from the op table: returns {err, carry, out}.
    function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel);
        int ua, ub, r, c, e;
        ua = int'(a);
        ub = int'(b);
        c  = 0;
        e  = 0;
        case (sel)
            4'h0: begin r = (ua + ub) % 256; c = (ua + ub > 255) ? 1 : 0; end
            4'h1: begin r = (ua - ub + 256) % 256; c = (ua < ub) ? 1 : 0; end
            4'h2: begin r = (ua * ub) % 256; c = (ua * ub > 255) ? 1 : 0; end
            4'h3: begin
                if (ub == 0) begin r = 255; e = 1; end
                else begin r = ua / ub; end
            end
            4'h4: r = (ua * 2) % 256;
            4'h5: r = ua / 2;
            4'h6: r = (ua * 2) % 256 + ua / 128;
            4'h7: r = ua / 2 + (ua % 2) * 128;
            4'h8: r = int'(a & b);
            4'h9: r = int'(a | b);
            4'hA: r = int'(a ^ b);
            4'hB: r = 255 - int'(a | b);
            4'hC: r = 255 - int'(a & b);
            4'hD: r = 255 - int'(a ^ b);
            4'hE: r = (ua > ub) ? 1 : 0;
            default: r = (ua == ub) ? 1 : 0;
        endcase
        return {e[0], c[0], r[7:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one command with rsp_ready held high; check latency, busy state, result and count.
    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel);
        logic [9:0] exp;
        int lat, exp_lat;
        exp     = model(a, b, sel);
        exp_lat = (sel == 4'd3 && b != 8'd0) ? 9 : 1;
        chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        cmd_a = a; cmd_b = b; cmd_sel = sel; cmd_valid = 1'b1; rsp_ready = 1'b1;
        @(posedge clk); #1;
        // Junk command held while busy must be ignored and must not disturb the result.
        cmd_a = 8'($urandom); cmd_b = 8'($urandom); cmd_sel = 4'($urandom);
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 20) begin
            chk("busy_cmd_ready", 32'(cmd_ready), 32'd0);
            @(posedge clk); #1;
            lat++;
        end
        cmd_valid = 1'b0;
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("resp_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rsp_out", 32'(rsp_out), 32'(exp[7:0]));
        chk("rsp_carry", 32'(rsp_carry), 32'(exp[8]));
        chk("rsp_err", 32'(rsp_err), 32'(exp[9]));
        @(posedge clk); #1;
        exp_count++;
        chk("op_count", 32'(op_count), 32'(exp_count % 16));
        chk("after_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("after_cmd_ready", 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        logic [7:0] ra, rb;
        logic [3:0] rs;
        int         start_count;

        rst = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
        cmd_a = 8'd0; cmd_b = 8'd0; cmd_sel = 4'd0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_op_count", 32'(op_count), 32'd0);
        chk("rst_rsp_out", 32'(rsp_out), 32'd0);
        chk("rst_rsp_carry", 32'(rsp_carry), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);

        // Reset during divide iteration 4: no response, back to idle, count unchanged
        cmd_a = 8'd200; cmd_b = 8'd7; cmd_sel = 4'd3; cmd_valid = 1'b1; rsp_ready = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("divrst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("divrst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("divrst_op_count", 32'(op_count), 32'd0);
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            chk("divrst_no_pulse", 32'(rsp_valid), 32'd0);
        end

        // Directed operations
        do_op(8'hFF, 8'h01, 4'h0);
        do_op(8'h05, 8'h07, 4'h1);
        do_op(8'h10, 8'h20, 4'h2);
        do_op(8'h01, 8'h00, 4'h7);
        do_op(8'd200, 8'd7, 4'h3);
        do_op(8'd5, 8'd0, 4'h3);
        do_op(8'hFF, 8'h01, 4'h3);
        do_op(8'h81, 8'h00, 4'h6);

        // Backpressure on EQ
        chk("bp_cmd_ready", 32'(cmd_ready), 32'd1);
        cmd_a = 8'h3C; cmd_b = 8'h3C; cmd_sel = 4'hF; cmd_valid = 1'b1; rsp_ready = 1'b0;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_rsp_out", 32'(rsp_out), 32'd1);
            chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
            chk("bp_op_count", 32'(op_count), 32'(exp_count % 16));
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        exp_count++;
        chk("bp_release_count", 32'(op_count), 32'(exp_count % 16));
        chk("bp_release_ready", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;
        chk("bp_single_incr", 32'(op_count), 32'(exp_count % 16));

        // 16 XOR commands on random operands: the 4-bit counter comes back around
        start_count = exp_count;
        for (int i = 0; i < 16; i++) begin
            ra = 8'($urandom); rb = 8'($urandom);
            do_op(ra, rb, 4'hA);
        end
        chk("wrap_count", 32'(op_count), 32'(start_count % 16));

        // Random mix of all operations, including occasional divide by zero
        for (int i = 0; i < 40; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rs = 4'($urandom);
            if ($urandom_range(0, 7) == 0) rb = 8'd0;
            do_op(ra, rb, rs);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_cmd_engine.md
Name: alu_cmd_engine

Overview:
- Registered, handshaked front end for the 8-bit ALU function set.
- The bench/stimulus side issues commands (A, B, select); this block responds with the result, carry and error flag over a valid/ready response channel.
- Simple ops complete in 1 cycle. Divide is a multi-cycle iterative unit.
- Used as the responder end of the ALU command interface in system-level benches and integration.

Parameters:
- CNT_W, 16, width of completed-operation counter (wraps modulo 2^CNT_W)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  engine can accept command
- cmd_a  in  8  operand A
- cmd_b  in  8  operand B
- cmd_sel  in  4  operation select
- rsp_valid  out  1  result present
- rsp_ready  in  1  consumer accepts result
- rsp_out  out  8  result
- rsp_carry  out  1  carry/borrow/overflow flag
- rsp_err  out  1  illegal operation (divide by zero)
- op_count  out  CNT_W  completed responses

Behaviour:
- Reset (sync, rst=1 at posedge):
  - state=IDLE; rsp_valid=0, rsp_out=0, rsp_carry=0, rsp_err=0, op_count=0.
  - cmd_ready=1 from the first cycle after reset.
  - Reset overrides everything, including an in-flight divide, which is discarded with no response.
- States: IDLE, DIV, RESP.
  - cmd_ready=1 only in IDLE (combinational from state).
  - rsp_valid=1 only in RESP.
- IDLE, cmd_valid=1: command is latched. Then:
  - cmd_sel=3 with cmd_b!=0: go to DIV.
  - Any other command: result computed and registered, go to RESP. rsp_valid is high the cycle after acceptance (latency 1).
- Op set, all unsigned, 8-bit result:
  - 0 ADD: out=(A+B)[7:0], carry=(A+B)[8]
  - 1 SUB: out=(A-B)[7:0], carry=1 iff A<B (borrow)
  - 2 MUL: out=(A*B)[7:0], carry=1 iff (A*B)[15:8]!=0
  - 3 DIV: out=A/B quotient, carry=0
  - 4 SHL: A<<1
  - 5 SHR: A>>1
  - 6 ROL: rotate A left by 1
  - 7 ROR: rotate A right by 1
  - 8 AND, 9 OR, A XOR, B NOR, C NAND, D XNOR
  - E GT: out=1 if A>B else 0
  - F EQ: out=1 if A==B else 0
  - carry=0 and err=0 for every op not listed with a flag.
- Divide by zero (sel=3, B=0): out=8'hFF, carry=0, err=1; no DIV state, latency 1.
- DIV:
  - Restoring shift-subtract divider, one quotient bit per cycle, 8 iterations, 4-bit iteration counter.
  - Accepted at cycle N, so rsp_valid is first high at cycle N+9.
  - Remainder is not reported.
  - cmd_valid is ignored while busy.
- RESP:
  - rsp_out, rsp_carry and rsp_err stay stable while rsp_valid=1 and rsp_ready=0.
  - On rsp_valid&rsp_ready: op_count+=1 (wraps), return to IDLE. cmd_ready is high the next cycle.
  - No same-cycle response-to-command pass-through: maximum throughput is one command per 2 cycles.
- Outputs hold their last values while not valid.
- Commands arriving when cmd_ready=0 are not latched; the initiator must hold them.

Test Plan:
- Reset → rsp_valid=0, cmd_ready=1, op_count=0, rsp_out=0. Assert rst during DIV at iteration 4 → next cycle IDLE, no rsp_valid pulse, op_count unchanged.
- ADD A=8'hFF B=8'h01, accepted cycle N, rsp_ready=1 → cycle N+1: rsp_valid=1, rsp_out=8'h00, rsp_carry=1, rsp_err=0; op_count=1 after.
- SUB A=8'h05 B=8'h07 → rsp_out=8'hFE, carry=1. MUL A=8'h10 B=8'h20 → out=8'h00, carry=1. ROR A=8'h01 → 8'h80.
- DIV A=200 B=7, accepted cycle N → cmd_ready=0 for N+1..N+9, rsp_valid first high at N+9, rsp_out=28, err=0. DIV A=5 B=0 → N+1: rsp_out=8'hFF, err=1.
- Backpressure: EQ A=B=8'h3C with rsp_ready=0 for 3 cycles → rsp_out=1 held stable, cmd_ready=0, op_count unchanged; raise rsp_ready → op_count increments once, cmd_ready=1 next cycle.
- Counter wrap with CNT_W=4: 16 back-to-back XOR commands → op_count returns to 0. Each response matches A^B on random operands.
